// File: rtl/fa3.sv
`default_nettype none
// ============================================================================
// Module      : fa3
// Description : Parameterisable-width ripple-carry full adder with optionally
//               registered sum/carry outputs. At WIDTH=1 this is a plain full
//               adder cell.
// Ports       : clk   - rising-edge clock (unused when REGISTERED=0)
//               rst_n - asynchronous active-low reset (unused when REGISTERED=0)
//               A, B  - WIDTH-bit unsigned operands
//               ci    - carry-in into bit 0
//               s     - sum, (A + B + ci) mod 2^WIDTH
//               co    - carry-out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module fa3 #(
    parameter int WIDTH      = 1,
    parameter int REGISTERED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    // Carry chain: c_d[0] is the carry-in, c_d[WIDTH] is the carry-out.
    logic [WIDTH:0]   c_d;
    logic [WIDTH-1:0] s_d;
    logic             co_d;

    assign c_d[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s_d[i]   = A[i] ^ B[i] ^ c_d[i];
        assign c_d[i+1] = (A[i] & B[i]) | (A[i] & c_d[i]) | (B[i] & c_d[i]);
    end

    assign co_d = c_d[WIDTH];

    if (REGISTERED != 0) begin : g_reg
        logic [WIDTH-1:0] s_q;
        logic             co_q;

        // No enable: a fresh result is captured every cycle, and an
        // asynchronous reset discards whatever was pending.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q  <= '0;
                co_q <= 1'b0;
            end else begin
                s_q  <= s_d;
                co_q <= co_d;
            end
        end

        assign s  = s_q;
        assign co = co_q;
    end else begin : g_comb
        // Clock and reset are deliberately ignored in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst_n;

        assign s  = s_d;
        assign co = co_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_fa3.sv
`default_nettype none
// ============================================================================
// Module      : tb_fa3
// Description : Self-checking bench for fa3. Three instances run side by
//               side: WIDTH=1 registered, WIDTH=1 combinational, and WIDTH=4
//               registered. Inputs change on the falling clock edge; outputs
//               are sampled 1 time unit after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fa3;

    logic       clk;
    logic       rst_n;
    logic       a1, b1, c1;
    logic       s_r, co_r;   // WIDTH=1, registered
    logic       s_c, co_c;   // WIDTH=1, combinational
    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] s_w;
    logic       co_w;

    int errors;
    int checks;

    fa3 #(.WIDTH(1), .REGISTERED(1)) u_reg1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .ci(c1), .s(s_r), .co(co_r)
    );

    fa3 #(.WIDTH(1), .REGISTERED(0)) u_comb1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .ci(c1), .s(s_c), .co(co_c)
    );

    fa3 #(.WIDTH(4), .REGISTERED(1)) u_reg4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .ci(c4), .s(s_w), .co(co_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic exp_co;
        logic exp_s;
    } vec1_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic       exp_co;
        logic [3:0] exp_s;
    } vec4_t;

    vec1_t tbl1[8];
    vec4_t tbl4[5];

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // (A,B,ci) -> (co,s), hand-computed
        tbl1[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl1[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl1[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl1[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl1[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl1[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl1[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl1[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        tbl4[0] = '{4'hF, 4'h1, 1'b0, 1'b1, 4'h0};
        tbl4[1] = '{4'h7, 4'h8, 1'b1, 1'b1, 4'h0};
        tbl4[2] = '{4'h3, 4'h4, 1'b0, 1'b0, 4'h7};
        tbl4[3] = '{4'h9, 4'h3, 1'b0, 1'b0, 4'hC};
        tbl4[4] = '{4'hA, 4'h5, 1'b1, 1'b1, 4'h0};

        // ---------------- Reset behaviour ----------------
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        #2 rst_n = 1'b0;                      // asserted before any clock edge
        #1;
        chk("reset_immediate_r1", {3'b0, co_r, s_r}, 5'b00000);
        chk("reset_immediate_r4", {co_w, s_w}, 5'b00000);
        chk("reset_comb_ignored", {3'b0, co_c, s_c}, 5'b00011);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_held_r1", {3'b0, co_r, s_r}, 5'b00000);
        chk("reset_held_r4", {co_w, s_w}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_release_r1", {3'b0, co_r, s_r}, 5'b00011);
        chk("reset_release_r4", {co_w, s_w}, 5'b11111);   // F+F+1 = 0x1F

        // ---------------- Exhaustive WIDTH=1 table ----------------
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = tbl1[i].a; b1 = tbl1[i].b; c1 = tbl1[i].c;
            #1;
            chk($sformatf("comb_vec%0d", i), {3'b0, co_c, s_c},
                {3'b0, tbl1[i].exp_co, tbl1[i].exp_s});
            @(posedge clk); #1;
            chk($sformatf("reg_vec%0d", i), {3'b0, co_r, s_r},
                {3'b0, tbl1[i].exp_co, tbl1[i].exp_s});
        end

        // ---------------- Stability between edges ----------------
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        chk("stab_load", {3'b0, co_r, s_r}, 5'b00001);
        #2 a1 = 1'b0;                         // mid-cycle change
        #1;
        chk("stab_hold", {3'b0, co_r, s_r}, 5'b00001);
        chk("stab_comb_follows", {3'b0, co_c, s_c}, 5'b00000);
        @(posedge clk); #1;
        chk("stab_next_edge", {3'b0, co_r, s_r}, 5'b00000);

        // ---------------- Mid-run reset pulse ----------------
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        chk("mid_pre", {3'b0, co_r, s_r}, 5'b00001);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_pulse_r1", {3'b0, co_r, s_r}, 5'b00000);
        chk("mid_pulse_comb", {3'b0, co_c, s_c}, 5'b00010);
        #1 rst_n = 1'b1;                      // released before the next edge
        #1;
        chk("mid_after_release", {3'b0, co_r, s_r}, 5'b00000);
        @(posedge clk); #1;
        chk("mid_first_edge", {3'b0, co_r, s_r}, 5'b00010);

        // ---------------- Wide mode WIDTH=4 ----------------
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = tbl4[i].a; b4 = tbl4[i].b; c4 = tbl4[i].c;
            @(posedge clk); #1;
            chk($sformatf("wide_vec%0d", i), {co_w, s_w},
                {tbl4[i].exp_co, tbl4[i].exp_s});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fa3.md
# fa3

Single-bit (parameterisable-width) full-adder cell with registered sum and carry outputs. It adds two operand bits and a carry-in and presents the sum and carry-out one clock after sampling. It is the basic arithmetic leaf used when composing ripple adders and arithmetic test structures in the lab designs.

## Interface

Parameters:
- `WIDTH`, default 1: operand width in bits. At 1 the block is a plain full adder.
- `REGISTERED`, default 1: 1 registers the outputs; 0 drives `s`/`co` combinationally and `clk`/`rst_n` are unused.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `A`  input  WIDTH  operand A.
- `B`  input  WIDTH  operand B.
- `ci`  input  1  carry-in into bit 0.
- `s`  output  WIDTH  sum, `(A + B + ci) mod 2^WIDTH`.
- `co`  output  1  carry-out of the MSB, bit WIDTH of `A + B + ci`.

## Operation

- Bit i sum: `s[i] = A[i] ^ B[i] ^ c[i]`.
- Bit i carry: `c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i])`, with `c[0] = ci`.
- Carry ripples LSB to MSB. `co = c[WIDTH]`.
- Arithmetic is unsigned. The full result `{co, s}` is WIDTH+1 bits and never saturates.
- With `REGISTERED=1`, on each rising `clk` the block samples `A`, `B` and `ci` and loads the computed `s`/`co` into output registers. It has no enable, so it samples every cycle.
- It has no state machine and no handshake. Each cycle is independent and no internal state is carried between cycles.
- X or Z on any input propagates to the outputs per normal Verilog semantics. No masking is done.

## Timing

- Reset: `rst_n` low forces `s = 0` and `co = 0` immediately, with no dependence on `clk`. They stay 0 while `rst_n` is low.
- Reset release is synchronous in effect. The first rising `clk` with `rst_n` high loads the result of the inputs present at that edge.
- Reset asserted mid-operation: the outputs clear at once and the pending result is discarded. No partial result appears after release.
- Latency is 1 cycle. Inputs stable at edge N appear on `s`/`co` just after edge N and are held until edge N+1.
- Throughput is one new operation per cycle.
- Input changes between edges have no effect on the outputs until the next edge.
- `REGISTERED=0`: the outputs are purely combinational from `A`/`B`/`ci`, the latency is zero, and reset has no effect.
- Critical path is the WIDTH-stage carry ripple. No timing requirement beyond meeting `clk` at the target WIDTH.

## Test plan

- Reset: assert `rst_n=0` with `A=1, B=1, ci=1` -> `s=0, co=0` immediately and held. Release -> next edge gives `s=1, co=1`.
- Exhaustive WIDTH=1, REGISTERED=1: apply `(A,B,ci)` = 111, 110, 101, 100, 011, 010, 001, 000, one vector per clock. The outputs one cycle later must be `(co,s)` = 11, 10, 10, 01, 10, 01, 01, 00.
- Stability: change `A` between clock edges -> `s`/`co` unchanged until the next rising edge.
- Mid-run reset: pulse `rst_n` low for less than one cycle while `A=1, B=1, ci=0` -> `s=0, co=0` during the pulse. The correct result `s=0, co=1` follows at the first edge after release.
- Combinational mode, `REGISTERED=0`: apply the 8 vectors above -> the outputs match the same table with zero latency, and toggling `rst_n` has no effect.
- Wide mode, `WIDTH=4`: `A=4'hF, B=4'h1, ci=0` -> `s=4'h0, co=1`. `A=4'h7, B=4'h8, ci=1` -> `s=4'h0, co=1`. `A=4'h3, B=4'h4, ci=0` -> `s=4'h7, co=0`.
